// File: rtl/stack_game_pkg.sv
// Shared types and constants for the stacking-game controller.
package stack_game_pkg;

  localparam int BLOCK_W = 8;
  localparam logic [BLOCK_W-1:0] INIT_BLOCK_DEFAULT = 8'b00111000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_LAND,
    S_WIN,
    S_LOSE
  } state_t;

  // Shift period for a row; speedup shortens it per row down to a floor.
  function automatic int step_period(input int base, input int dec, input int minp,
                                     input int row, input bit speedup);
    int p;
    p = base;
    if (speedup) begin
      p = base - row * dec;
      if (p < minp) p = minp;
    end
    return p;
  endfunction

endpackage

// File: rtl/stack_game_ctrl_if.sv
// Controller-to-shifter link: block feedback in, step/load strobes out.
interface stack_game_ctrl_if;

  logic [stack_game_pkg::BLOCK_W-1:0] curBlock;
  logic [stack_game_pkg::BLOCK_W-1:0] loadBlock;
  logic                               stepPulse;
  logic                               loadEn;

  modport master (input curBlock, output stepPulse, output loadEn, output loadBlock);
  modport slave  (output curBlock, input stepPulse, input loadEn, input loadBlock);

endinterface

// File: rtl/stack_game_ctrl_btn_edge.sv
// Button level register with rising-edge detect.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/stack_game_ctrl.sv
// Stacking-game controller: drives a block shifter, lands blocks on a stack.
// Optional per-row speedup of the shift period under macro STACK_SPEEDUP_EN.
module stack_game_ctrl
  import stack_game_pkg::*;
#(
  parameter int                 ROWS        = 8,
  parameter logic [BLOCK_W-1:0] INIT_BLOCK  = INIT_BLOCK_DEFAULT,
  parameter int                 BASE_PERIOD = 16,
  parameter int                 PERIOD_DEC  = 2,
  parameter int                 MIN_PERIOD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 startBtn,
  input  logic                 stopBtn,
  stack_game_ctrl_if.master    sh,
  input  logic [2:0]           rdRow,
  output logic [BLOCK_W-1:0]   rdData,
  output logic [2:0]           curRow,
  output logic [3:0]           score,
  output logic                 gameOver,
  output logic                 gameWin
);

`ifdef STACK_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif
  localparam int PMAX  = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
  localparam int CNT_W = $clog2(PMAX);

  state_t             state, state_nxt;
  logic               start_rise, stop_rise;
  logic [BLOCK_W-1:0] stack [8];
  logic [BLOCK_W-1:0] landed, next_block, below;
  logic [CNT_W-1:0]   step_cnt, period_m1;
  logic               step_wrap;
  logic               game_clear, land_capture, land_write, cnt_clear, cnt_run;
  logic               step_pulse, load_en;

  btn_edge u_start_edge (.clk(clk), .rst_n(rst_n), .level(startBtn), .rise(start_rise));
  btn_edge u_stop_edge  (.clk(clk), .rst_n(rst_n), .level(stopBtn),  .rise(stop_rise));

  assign period_m1 = CNT_W'(step_period(BASE_PERIOD, PERIOD_DEC, MIN_PERIOD,
                                        int'(curRow), SPEEDUP) - 1);
  assign step_wrap = (step_cnt == period_m1);
  assign below     = (curRow == 3'd0) ? '1 : stack[curRow - 3'd1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    game_clear   = 1'b0;
    land_capture = 1'b0;
    land_write   = 1'b0;
    cnt_clear    = 1'b0;
    cnt_run      = 1'b0;
    step_pulse   = 1'b0;
    load_en      = 1'b0;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_rise) begin
          game_clear = 1'b1;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en   = 1'b1;
        cnt_clear = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // A stop wins over a coinciding step so the captured block is the one shown.
        if (stop_rise) begin
          land_capture = 1'b1;
          state_nxt    = S_LAND;
        end else begin
          cnt_run    = 1'b1;
          step_pulse = step_wrap;
        end
      end
      S_LAND: begin
        if (landed == '0) begin
          state_nxt = S_LOSE;
        end else begin
          land_write = 1'b1;
          state_nxt  = (int'(curRow) == ROWS - 1) ? S_WIN : S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack      <= '{default: '0};
      curRow     <= '0;
      score      <= '0;
      next_block <= '0;
      landed     <= '0;
      step_cnt   <= '0;
    end else begin
      if (game_clear) begin
        stack      <= '{default: '0};
        curRow     <= '0;
        score      <= '0;
        next_block <= INIT_BLOCK;
      end
      if (land_capture) landed <= sh.curBlock & below;
      if (land_write) begin
        stack[curRow] <= landed;
        score         <= score + 4'd1;
        if (int'(curRow) != ROWS - 1) begin
          curRow     <= curRow + 3'd1;
          next_block <= landed;
        end
      end
      if (cnt_clear || (cnt_run && step_wrap)) step_cnt <= '0;
      else if (cnt_run)                        step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  assign sh.stepPulse = step_pulse;
  assign sh.loadEn    = load_en;
  assign sh.loadBlock = next_block;
  assign rdData       = (int'(rdRow) < ROWS) ? stack[rdRow] : '0;
  assign gameOver     = (state == S_LOSE);
  assign gameWin      = (state == S_WIN);

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Scoreboard bench for stack_game_ctrl: default 8-row instance plus a 2-row instance.
module tb_stack_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_start = 1'b0, a_stop = 1'b0, b_start = 1'b0, b_stop = 1'b0;
  logic [2:0] a_rdRow = '0, b_rdRow = '0;
  logic [7:0] a_rdData, b_rdData;
  logic [2:0] a_curRow, b_curRow;
  logic [3:0] a_score, b_score;
  logic       a_over, a_win, b_over, b_win;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

`ifdef STACK_SPEEDUP_EN
  localparam int P1 = 14, P2 = 12, P7 = 4;
`else
  localparam int P1 = 16, P2 = 16, P7 = 16;
`endif
  localparam int P0 = 16;

  stack_game_ctrl_if a_if ();
  stack_game_ctrl_if b_if ();

  stack_game_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .startBtn(a_start), .stopBtn(a_stop), .sh(a_if.master),
    .rdRow(a_rdRow), .rdData(a_rdData), .curRow(a_curRow), .score(a_score),
    .gameOver(a_over), .gameWin(a_win)
  );

  stack_game_ctrl #(.ROWS(2), .BASE_PERIOD(4)) u_b (
    .clk(clk), .rst_n(rst_n), .startBtn(b_start), .stopBtn(b_stop), .sh(b_if.master),
    .rdRow(b_rdRow), .rdData(b_rdData), .curRow(b_curRow), .score(b_score),
    .gameOver(b_over), .gameWin(b_win)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_btns();
    a_start = 1'b0; a_stop = 1'b0; b_start = 1'b0; b_stop = 1'b0;
  endtask

  task automatic rd(input bit b, input logic [2:0] r, output logic [7:0] d);
    if (b) b_rdRow = r; else a_rdRow = r;
    #1;
    d = b ? b_rdData : a_rdData;
  endtask

  // Waits for loadEn, pops the scoreboard and checks value and latency.
  task automatic check_load(input bit b, input int exp_wait, input string name);
    int n; bit seen; logic [7:0] exp, got;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk); n++;
      release_btns();
      if (b ? b_if.loadEn : a_if.loadEn) seen = 1'b1;
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      fails++; $display("FAIL %s: scoreboard empty at load", name);
    end else begin
      exp = exp_q.pop_front();
      got = b ? b_if.loadBlock : a_if.loadBlock;
      if (!seen) begin
        fails++; $display("FAIL %s: no loadEn within 10 cycles, expected %b", name, exp);
      end else begin
        if (got !== exp) begin
          fails++; $display("FAIL %s: loadBlock got %b expected %b", name, got, exp);
        end
        tests_run++;
        if (n != exp_wait) begin
          fails++; $display("FAIL %s_latency: got %0d expected %0d", name, n, exp_wait);
        end
        tests_run++;
        if ((b ? b_if.stepPulse : a_if.stepPulse) !== 1'b0) begin
          fails++; $display("FAIL %s_overlap: stepPulse got 1 expected 0 with loadEn", name);
        end
      end
    end
  endtask

  task automatic stop_and_load(input bit b, input logic [7:0] cb, input logic [7:0] exp,
                               input string name);
    logic [7:0] d;
    if (b) begin b_if.curBlock = cb; b_stop = 1'b1; end
    else   begin a_if.curBlock = cb; a_stop = 1'b1; end
    exp_q.push_back(exp);
    check_load(b, 2, name);
    rd(b, (b ? b_curRow : a_curRow) - 3'd1, d);
    tests_run++;
    if (d !== exp) begin
      fails++; $display("FAIL %s_stack: got %b expected %b", name, d, exp);
    end
  endtask

  task automatic wait_pulse(input string name);
    int n; bit ok;
    n = 0; ok = 1'b0;
    while (!ok && n < 80) begin
      @(negedge clk); n++;
      if (a_if.stepPulse) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin
      fails++; $display("FAIL %s: no stepPulse within 80 cycles", name);
    end
  endtask

  task automatic measure_period(input int exp, input string name);
    int n; bit ok;
    wait_pulse({name, "_first"});
    n = 0; ok = 1'b0;
    while (!ok && n < 80) begin
      @(negedge clk); n++;
      if (a_if.stepPulse) ok = 1'b1;
    end
    tests_run++;
    if (!ok || n != exp) begin
      fails++; $display("FAIL %s: spacing got %0d expected %0d", name, ok ? n : -1, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tick(2);
    tests_run++;
    if ({a_if.stepPulse, a_if.loadEn, a_over, a_win} !== 4'b0) begin
      fails++; $display("FAIL reset_strobes: got %b expected 0000",
                        {a_if.stepPulse, a_if.loadEn, a_over, a_win});
    end
    tests_run++;
    if ({a_if.loadBlock, a_curRow, a_score} !== 15'd0) begin
      fails++; $display("FAIL reset_regs: got %h/%0d/%0d expected 0/0/0",
                        a_if.loadBlock, a_curRow, a_score);
    end
    tests_run++;
    if ({b_if.stepPulse, b_if.loadEn, b_over, b_win, b_if.loadBlock} !== 12'd0) begin
      fails++; $display("FAIL reset_b: got %h expected 0",
                        {b_if.stepPulse, b_if.loadEn, b_over, b_win, b_if.loadBlock});
    end
    for (int r = 0; r < 8; r++) begin
      rd(1'b0, 3'(r), d);
      tests_run++;
      if (d !== 8'h00) begin
        fails++; $display("FAIL reset_row%0d: got %b expected 0", r, d);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_row0();
    a_start = 1'b1;
    exp_q.push_back(8'b00111000);
    check_load(1'b0, 1, "start_load");
    tests_run++;
    if ({a_curRow, a_score} !== 7'd0) begin
      fails++; $display("FAIL start_counters: got %0d/%0d expected 0/0", a_curRow, a_score);
    end
    measure_period(P0, "period_row0");
    wait_pulse("third_step");
    stop_and_load(1'b0, 8'b00111000, 8'b00111000, "land_row0");
    tests_run++;
    if ({a_curRow, a_score} !== {3'd1, 4'd1}) begin
      fails++; $display("FAIL row0_counters: got %0d/%0d expected 1/1", a_curRow, a_score);
    end
  endtask

  task automatic test_overlap_and_stop_on_wrap();
    tick(1);
    wait_pulse("row1_pulse");
    tick(P1);
    tests_run++;
    if (a_if.stepPulse !== 1'b1) begin
      fails++; $display("FAIL row1_wrap_pulse: got %b expected 1", a_if.stepPulse);
    end
    a_if.curBlock = 8'b00011100;
    a_stop = 1'b1;
    #1;
    tests_run++;
    if (a_if.stepPulse !== 1'b0) begin
      fails++; $display("FAIL stop_suppresses_step: got %b expected 0", a_if.stepPulse);
    end
    exp_q.push_back(8'b00011000);
    check_load(1'b0, 2, "land_row1");
    begin
      logic [7:0] d;
      rd(1'b0, 3'd1, d);
      tests_run++;
      if (d !== 8'b00011000) begin
        fails++; $display("FAIL row1_stack: got %b expected 00011000", d);
      end
    end
    tests_run++;
    if ({a_curRow, a_score} !== {3'd2, 4'd2}) begin
      fails++; $display("FAIL row1_counters: got %0d/%0d expected 2/2", a_curRow, a_score);
    end
  endtask

  task automatic test_game_to_win();
    bit saw_load;
    tick(1);
    measure_period(P2, "period_row2");
    a_start = 1'b1;
    saw_load = 1'b0;
    repeat (4) begin
      @(negedge clk); release_btns();
      saw_load |= a_if.loadEn;
    end
    tests_run++;
    if (saw_load || a_curRow !== 3'd2) begin
      fails++; $display("FAIL start_in_run_ignored: load %b row %0d expected 0 row 2",
                        saw_load, a_curRow);
    end
    stop_and_load(1'b0, 8'b00011000, 8'b00011000, "land_row2");
    for (int r = 3; r < 7; r++) begin
      tick(1);
      stop_and_load(1'b0, 8'b00011000, 8'b00011000, $sformatf("land_row%0d", r));
    end
    tick(1);
    measure_period(P7, "period_row7");
    a_if.curBlock = 8'b00011000;
    a_stop = 1'b1;
    @(negedge clk); release_btns();
    @(negedge clk);
    tests_run++;
    if ({a_win, a_over, a_if.loadEn, a_score} !== {3'b100, 4'd8}) begin
      fails++; $display("FAIL win8: win/over/load/score got %b/%b/%b/%0d expected 1/0/0/8",
                        a_win, a_over, a_if.loadEn, a_score);
    end
  endtask

  task automatic test_lose();
    logic [7:0] d;
    a_start = 1'b1;
    exp_q.push_back(8'b00111000);
    check_load(1'b0, 1, "restart_from_win");
    for (int r = 0; r < 8; r++) begin
      rd(1'b0, 3'(r), d);
      tests_run++;
      if (d !== 8'h00) begin
        fails++; $display("FAIL restart_clear_row%0d: got %b expected 0", r, d);
      end
    end
    tick(1);
    stop_and_load(1'b0, 8'b11100000, 8'b11100000, "lose_row0");
    tick(1);
    a_if.curBlock = 8'b00000111;
    a_stop = 1'b1;
    @(negedge clk); release_btns();
    @(negedge clk);
    tests_run++;
    if ({a_over, a_win, a_if.loadEn, a_score} !== {3'b100, 4'd1}) begin
      fails++; $display("FAIL lose: over/win/load/score got %b/%b/%b/%0d expected 1/0/0/1",
                        a_over, a_win, a_if.loadEn, a_score);
    end
    rd(1'b0, 3'd1, d);
    tests_run++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL lose_row1: got %b expected 0", d);
    end
    a_stop = 1'b1;
    @(negedge clk); release_btns();
    tick(3);
    tests_run++;
    if ({a_over, a_score} !== {1'b1, 4'd1}) begin
      fails++; $display("FAIL stop_in_lose: over/score got %b/%0d expected 1/1", a_over, a_score);
    end
  endtask

  task automatic test_win_rows2();
    logic [7:0] d;
    b_start = 1'b1;
    exp_q.push_back(8'b00111000);
    check_load(1'b1, 1, "b_start");
    tick(1);
    stop_and_load(1'b1, 8'b00111000, 8'b00111000, "b_row0");
    tick(1);
    b_if.curBlock = 8'b00111000;
    b_stop = 1'b1;
    @(negedge clk); release_btns();
    @(negedge clk);
    tests_run++;
    if ({b_win, b_over, b_score} !== {2'b10, 4'd2}) begin
      fails++; $display("FAIL b_win: win/over/score got %b/%b/%0d expected 1/0/2",
                        b_win, b_over, b_score);
    end
    b_stop = 1'b1;
    @(negedge clk); release_btns();
    tick(3);
    rd(1'b1, 3'd1, d);
    tests_run++;
    if ({b_win, b_score, d} !== {1'b1, 4'd2, 8'b00111000}) begin
      fails++; $display("FAIL b_stop_after_win: win/score/row1 got %b/%0d/%b expected 1/2/00111000",
                        b_win, b_score, d);
    end
    rd(1'b1, 3'd2, d);
    tests_run++;
    if (d !== 8'h00) begin
      fails++; $display("FAIL b_row_out_of_range: got %b expected 0", d);
    end
    b_start = 1'b1;
    exp_q.push_back(8'b00111000);
    check_load(1'b1, 1, "b_restart");
    for (int r = 0; r < 2; r++) begin
      rd(1'b1, 3'(r), d);
      tests_run++;
      if (d !== 8'h00) begin
        fails++; $display("FAIL b_restart_row%0d: got %b expected 0", r, d);
      end
    end
    tests_run++;
    if ({b_win, b_score} !== 5'd0) begin
      fails++; $display("FAIL b_restart_flags: win/score got %b/%0d expected 0/0", b_win, b_score);
    end
  endtask

  task automatic test_reset_midgame();
    logic [7:0] d;
    bit saw_load;
    a_start = 1'b1;
    exp_q.push_back(8'b00111000);
    check_load(1'b0, 1, "restart_from_lose");
    tests_run++;
    if (a_over !== 1'b0) begin
      fails++; $display("FAIL restart_clears_over: got %b expected 0", a_over);
    end
    for (int r = 0; r < 3; r++) begin
      tick(1);
      stop_and_load(1'b0, 8'b00111000, 8'b00111000, $sformatf("pre_reset_row%0d", r));
    end
    tick(4);
    a_if.curBlock = 8'b00111000;
    a_stop = 1'b1;
    @(negedge clk); release_btns();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_if.stepPulse, a_if.loadEn, a_over, a_win, a_if.loadBlock, a_curRow, a_score} !== 19'd0) begin
      fails++; $display("FAIL midgame_reset: got %h expected 0",
                        {a_if.stepPulse, a_if.loadEn, a_over, a_win, a_if.loadBlock, a_curRow, a_score});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    for (int r = 0; r < 8; r++) begin
      rd(1'b0, 3'(r), d);
      tests_run++;
      if (d !== 8'h00) begin
        fails++; $display("FAIL post_reset_row%0d: got %b expected 0", r, d);
      end
    end
    a_stop = 1'b1;
    saw_load = 1'b0;
    repeat (4) begin
      @(negedge clk); release_btns();
      saw_load |= a_if.loadEn;
    end
    tests_run++;
    if (saw_load || {a_over, a_curRow, a_score} !== 8'd0) begin
      fails++; $display("FAIL stop_after_reset_ignored: load %b over/row/score %b/%0d/%0d expected 0",
                        saw_load, a_over, a_curRow, a_score);
    end
    a_start = 1'b1;
    exp_q.push_back(8'b00111000);
    check_load(1'b0, 1, "start_after_reset");
  endtask

  initial begin
    a_if.curBlock = '0;
    b_if.curBlock = '0;
    test_reset();
    test_row0();
    test_overlap_and_stop_on_wrap();
    test_game_to_win();
    test_lose();
    test_win_rows2();
    test_reset_midgame();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/stack_game_ctrl.md
STACK_GAME_CTRL -- requirements
Module: stack_game_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of stack rows (2..8).
REQ-002 SHALL have parameter INIT_BLOCK, default 8'b00111000, block loaded at game start.
REQ-003 SHALL have parameter BASE_PERIOD, default 16, clk cycles per shift step on row 0 (>=2).
REQ-004 SHALL have parameter PERIOD_DEC, default 2, period reduction per row when speedup is compiled in.
REQ-005 SHALL have parameter MIN_PERIOD, default 4, floor on the step period (>=2).
REQ-006 SHALL have port clk  in  1  single system clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port startBtn  in  1  start/restart button, level input, synchronous to clk.
REQ-009 SHALL have port stopBtn  in  1  stop/drop button, level input, synchronous to clk.
REQ-010 SHALL have port curBlock  in  8  live block position returned by the shifter.
REQ-011 SHALL have port stepPulse  out  1  one-cycle shift strobe to the shifter.
REQ-012 SHALL have port loadEn  out  1  one-cycle load strobe to the shifter.
REQ-013 SHALL have port loadBlock  out  8  block value presented with loadEn.
REQ-014 SHALL have port rdRow  in  3  stack row index to read, for the display.
REQ-015 SHALL have port rdData  out  8  combinational contents of stack row rdRow; 0 if rdRow>=ROWS.
REQ-016 SHALL have port curRow  out  3  active row index.
REQ-017 SHALL have port score  out  4  number of rows landed.
REQ-018 SHALL have port gameOver  out  1  high while in LOSE.
REQ-019 SHALL have port gameWin  out  1  high while in WIN.

Function
REQ-020 SHALL act on rising edges of startBtn/stopBtn only: previous level registered, rise = level & ~prev.
REQ-021 SHALL implement states IDLE, LOAD, RUN, LAND, WIN, LOSE.
REQ-022 IDLE: startRise -> clear all stack rows, curRow=0, score=0, next block=INIT_BLOCK, go to LOAD.
REQ-023 LOAD: assert loadEn with loadBlock=next block for exactly one cycle, clear step counter, go to RUN.
REQ-024 RUN: step counter counts clk cycles; when it reaches period-1, assert stepPulse for one cycle and wrap to 0.
REQ-025 RUN + stopRise: register landed = curBlock & below (below = 8'hFF for row 0, otherwise stack[curRow-1]); go to LAND; no stepPulse that cycle, even if the counter wraps.
REQ-026 LAND with landed==0: go to LOSE; no stack write.
REQ-027 LAND with landed!=0: stack[curRow]=landed, score+1; if curRow==ROWS-1 go to WIN, else curRow+1, next block=landed, go to LOAD.
REQ-028 WIN/LOSE: hold with stack frozen; startRise behaves as in IDLE (restart).
REQ-029 stopRise outside RUN and startRise in LOAD/RUN/LAND SHALL be ignored.
REQ-030 stepPulse and loadEn SHALL never be asserted in the same cycle.
REQ-031 Latency: stopRise-to-stack-write = 2 cycles; stopRise-to-loadEn = 2 cycles.

Reset
REQ-032 On rst_n low (asynchronous): state=IDLE, stack all 0, curRow=0, score=0, step counter=0, button history=0, stepPulse=loadEn=0, loadBlock=0, gameOver=gameWin=0.
REQ-033 Reset asserted mid-game SHALL abort immediately; no partial stack write survives.

Configuration
REQ-034 Macro STACK_SPEEDUP_EN defined: period = max(BASE_PERIOD - curRow*PERIOD_DEC, MIN_PERIOD).
REQ-035 STACK_SPEEDUP_EN undefined: period = BASE_PERIOD on every row; PERIOD_DEC and MIN_PERIOD unused.

Structure
REQ-036 Shared package stack_game_pkg SHALL hold the state enumeration, the 8-bit block width constant and the default INIT_BLOCK.
REQ-037 SHALL instantiate one sub-module btn_edge (register plus rise detect), once per button.

Verification
REQ-038 Start, wait 3 steps, stop with curBlock=8'b00111000 -> stack[0]=8'b00111000, score=1, loadEn with loadBlock=8'b00111000 two cycles after stopRise.
REQ-039 Row 1 stop with curBlock=8'b00011100 over stack[0]=8'b00111000 -> stack[1]=8'b00011000, next loadBlock=8'b00011000.
REQ-040 Stop with curBlock=8'b00000111 over stack[0]=8'b11100000 -> gameOver=1, score unchanged, stack[1] stays 0.
REQ-041 ROWS=2, two aligned stops -> gameWin=1, score=2; a further stopRise has no effect; startRise -> stack cleared, loadEn with 8'b00111000.
REQ-042 With STACK_SPEEDUP_EN, BASE_PERIOD=16, PERIOD_DEC=2, MIN_PERIOD=4: stepPulse spacing 16 on row 0, 12 on row 2, 4 on row 7.
REQ-043 rst_n pulsed low mid-RUN on row 3 -> all outputs at reset values in the same cycle; stopRise then ignored until startRise.
